// File: rtl/mips_run_pkg.sv
// mips_run_pkg
//   Shared types and default constants for the MIPS run monitor.
//   - run_state_t : run controller states (IDLE, HOLD, ARM, RUN, DONE)
//   - DEF_*       : default parameter values for the monitor
package mips_run_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } run_state_t;

  localparam int DEF_RESET_CYCLES   = 1;
  localparam int DEF_TIMEOUT_CYCLES = 10000;
  localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/mips_run_monitor_sat_counter.sv
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset, clears the count
//     clr   - synchronous clear (priority over inc)
//     inc   - advance by one when not already saturated
//     count - current value, CNT_W bits
module sat_counter
  import mips_run_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// mips_run_monitor
//   Run controller / monitor for mips_cpu_harvard. Holds the CPU in reset
//   for RESET_CYCLES after a start pulse, checks the CPU comes up active,
//   then counts active cycles and data-port strobes until the CPU halts
//   (active drops) or TIMEOUT_CYCLES active cycles elapse. register_v0 is
//   captured on the terminating edge.
//   Ports:
//     clk             - clock, rising edge
//     reset           - asynchronous active-low reset of the monitor
//     start           - one-cycle pulse, begins a run from IDLE or DONE
//     cpu_reset       - registered active-high reset to the CPU
//     cpu_active      - CPU active output
//     cpu_register_v0 - CPU register_v0 output
//     cpu_data_read   - CPU data read strobe
//     cpu_data_write  - CPU data write strobe
//     busy            - run in progress (HOLD, ARM, RUN)
//     done            - run finished, held until the next start
//     timeout         - run aborted after TIMEOUT_CYCLES active cycles
//     no_start_err    - CPU was not active on the first un-reset cycle
//     rw_conflict     - read and write strobes seen together during RUN
//     v0_result       - register_v0 captured when the run ended
//     cycle_count     - RUN cycles with cpu_active high
//     read_count      - RUN cycles with cpu_data_read high
//     write_count     - RUN cycles with cpu_data_write high
module mips_run_monitor
  import mips_run_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             cpu_reset,
  input  logic             cpu_active,
  input  logic [31:0]      cpu_register_v0,
  input  logic             cpu_data_read,
  input  logic             cpu_data_write,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             no_start_err,
  output logic             rw_conflict,
  output logic [31:0]      v0_result,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] write_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  // The timeout fires on the active cycle that takes cycle_count to
  // TIMEOUT_CYCLES, i.e. when the pre-increment value is TIMEOUT_CYCLES-1.
  // Compared at 64 bits so any CNT_W / TIMEOUT_CYCLES combination is exact.
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_reset_q;

  logic cnt_clr;
  logic run_cnt;
  logic cap_v0;
  logic set_to;
  logic set_nse;
  logic at_limit;

  assign at_limit = (64'(cycle_count) >= TO_LAST);

  // ---- next-state / control decode
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_clr = 1'b0;
    run_cnt = 1'b0;
    cap_v0  = 1'b0;
    set_to  = 1'b0;
    set_nse = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
          cnt_clr = 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = ARM;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      ARM: begin
        if (cpu_active) begin
          state_d = RUN;
        end else begin
          set_nse = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        if (!cpu_active) begin
          // Halt: strobes on this cycle are not counted.
          cap_v0  = 1'b1;
          state_d = DONE;
        end else begin
          run_cnt = 1'b1;
          if (at_limit) begin
            set_to  = 1'b1;
            cap_v0  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      // Decoded from the next state so the CPU reset is a clean flop output.
      cpu_reset_q <= !((state_d == ARM) || (state_d == RUN));
    end
  end

  // ---- result flags and captured register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout      <= 1'b0;
      no_start_err <= 1'b0;
      rw_conflict  <= 1'b0;
      v0_result    <= '0;
    end else if (cnt_clr) begin
      timeout      <= 1'b0;
      no_start_err <= 1'b0;
      rw_conflict  <= 1'b0;
      v0_result    <= '0;
    end else begin
      if (set_to) begin
        timeout <= 1'b1;
      end
      if (set_nse) begin
        no_start_err <= 1'b1;
      end
      if (run_cnt && cpu_data_read && cpu_data_write) begin
        rw_conflict <= 1'b1;
      end
      if (cap_v0) begin
        v0_result <= cpu_register_v0;
      end
    end
  end

  // ---- activity counters
  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (run_cnt),
    .count (cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_read_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (run_cnt && cpu_data_read),
    .count (read_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (run_cnt && cpu_data_write),
    .count (write_count)
  );

  assign cpu_reset = cpu_reset_q;
  assign busy      = (state_q == HOLD) || (state_q == ARM) || (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mips_run_monitor.sv
module tb_mips_run_monitor;

  localparam int RC = 3;
  localparam int TO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        cpu_active;
  logic [31:0] cpu_register_v0;
  logic        cpu_data_read;
  logic        cpu_data_write;

  logic        cpu_reset, busy, done, timeout, no_start_err, rw_conflict;
  logic [31:0] v0_result, cycle_count, read_count, write_count;

  logic        b_cpu_reset, b_busy, b_done, b_timeout, b_no_start_err, b_rw_conflict;
  logic [31:0] b_v0_result;
  logic [3:0]  b_cycle_count, b_read_count, b_write_count;

  mips_run_monitor #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .cpu_reset(cpu_reset),
    .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
    .cpu_data_read(cpu_data_read), .cpu_data_write(cpu_data_write),
    .busy(busy), .done(done), .timeout(timeout), .no_start_err(no_start_err),
    .rw_conflict(rw_conflict), .v0_result(v0_result), .cycle_count(cycle_count),
    .read_count(read_count), .write_count(write_count)
  );

  mips_run_monitor #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(rst_n), .start(start), .cpu_reset(b_cpu_reset),
    .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
    .cpu_data_read(cpu_data_read), .cpu_data_write(cpu_data_write),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .no_start_err(b_no_start_err),
    .rw_conflict(b_rw_conflict), .v0_result(b_v0_result), .cycle_count(b_cycle_count),
    .read_count(b_read_count), .write_count(b_write_count)
  );

  typedef struct {
    int          act;
    logic [31:0] v0;
    int          nr;
    int          nw;
    int          ecc;
    int          erd;
    int          ewr;
    logic        eto;
    logic        ense;
    logic        econf;
    logic [31:0] ev0;
  } vec_t;

  vec_t tbl [6];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start from IDLE/DONE and return at the negedge of the ARM cycle.
  task automatic start_to_arm(input string tag);
    int hold;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 64'(busy), 64'(1));
    chk({tag, " done_dropped"}, 64'(done), 64'(0));
    hold = 0;
    while (cpu_reset && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    chk({tag, " cpu_reset_hold_cycles"}, 64'(hold), 64'(RC));
    chk({tag, " busy_in_arm"}, 64'(busy), 64'(1));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    cpu_register_v0 = v.v0;
    cpu_active      = 1'b0;
    cpu_data_read   = 1'b0;
    cpu_data_write  = 1'b0;
    start_to_arm(tag);
    cpu_active = (v.act > 0);
    @(negedge clk);
    for (int i = 0; i < v.act; i++) begin
      cpu_active     = 1'b1;
      cpu_data_read  = (i < v.nr);
      cpu_data_write = (i < v.nw);
      @(negedge clk);
    end
    // Halt cycle: strobes high but must not be counted.
    cpu_active     = 1'b0;
    cpu_data_read  = 1'b1;
    cpu_data_write = 1'b1;
    @(negedge clk);
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    chk({tag, " done"}, 64'(done), 64'(1));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " cpu_reset"}, 64'(cpu_reset), 64'(1));
    chk({tag, " timeout"}, 64'(timeout), 64'(v.eto));
    chk({tag, " no_start_err"}, 64'(no_start_err), 64'(v.ense));
    chk({tag, " rw_conflict"}, 64'(rw_conflict), 64'(v.econf));
    chk({tag, " v0_result"}, 64'(v0_result), 64'(v.ev0));
    chk({tag, " cycle_count"}, 64'(cycle_count), 64'(v.ecc));
    chk({tag, " read_count"}, 64'(read_count), 64'(v.erd));
    chk({tag, " write_count"}, 64'(write_count), 64'(v.ewr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{25, 32'h0000_0007, 4,  2,  25, 4,  2,  1'b0, 1'b0, 1'b1, 32'h0000_0007};
    tbl[1] = '{0,  32'h0000_1234, 0,  0,  0,  0,  0,  1'b0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[2] = '{60, 32'hDEAD_BEEF, 10, 55, 50, 10, 50, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{1,  32'hA5A5_A5A5, 1,  1,  1,  1,  1,  1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5};
    tbl[4] = '{5,  32'h0000_0042, 3,  0,  5,  3,  0,  1'b0, 1'b0, 1'b0, 32'h0000_0042};
    tbl[5] = '{20, 32'hCAFE_0001, 20, 20, 20, 20, 20, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001};

    rst_n           = 1'b0;
    start           = 1'b0;
    cpu_active      = 1'b0;
    cpu_register_v0 = '0;
    cpu_data_read   = 1'b0;
    cpu_data_write  = 1'b0;

    #22;
    chk("reset cpu_reset", 64'(cpu_reset), 64'(1));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset timeout", 64'(timeout), 64'(0));
    chk("reset v0_result", 64'(v0_result), 64'(0));
    chk("reset cycle_count", 64'(cycle_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle cpu_reset", 64'(cpu_reset), 64'(1));
    chk("idle done", 64'(done), 64'(0));

    for (int k = 0; k < 6; k++) begin
      run_vec(tbl[k], $sformatf("vec%0d", k));
    end

    // Narrow-counter instance saturates during the last vector.
    chk("sat done", 64'(b_done), 64'(1));
    chk("sat cycle_count", 64'(b_cycle_count), 64'(15));
    chk("sat read_count", 64'(b_read_count), 64'(15));
    chk("sat write_count", 64'(b_write_count), 64'(15));
    chk("sat rw_conflict", 64'(b_rw_conflict), 64'(1));
    chk("sat timeout", 64'(b_timeout), 64'(0));

    // Start ignored mid-run, then asynchronous reset at RUN cycle 10.
    cpu_register_v0 = 32'h1111_2222;
    start_to_arm("midreset");
    cpu_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      start          = (i == 4);
      cpu_data_read  = 1'b1;
      cpu_data_write = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("midrun cycle_count", 64'(cycle_count), 64'(10));
    chk("midrun read_count", 64'(read_count), 64'(10));
    chk("midrun cpu_reset", 64'(cpu_reset), 64'(0));
    chk("midrun busy", 64'(busy), 64'(1));
    chk("midrun rw_conflict", 64'(rw_conflict), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async cpu_reset", 64'(cpu_reset), 64'(1));
    chk("async busy", 64'(busy), 64'(0));
    chk("async done", 64'(done), 64'(0));
    chk("async rw_conflict", 64'(rw_conflict), 64'(0));
    chk("async cycle_count", 64'(cycle_count), 64'(0));
    chk("async read_count", 64'(read_count), 64'(0));
    chk("async write_count", 64'(write_count), 64'(0));
    chk("async v0_result", 64'(v0_result), 64'(0));
    cpu_active     = 1'b0;
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset done", 64'(done), 64'(0));

    run_vec(tbl[0], "rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Synthesizable run controller/monitor sitting directly downstream of mips_cpu_harvard: drives the CPU's reset, watches active, captures register_v0 on halt, counts cycles and data-port traffic.
- Replaces the behavioural reset/halt-wait sequence in the harvard bench, so the same run/timeout/result logic can sit in benches and FPGA builds alongside data_mem and instr_mem.

Parameters:
- RESET_CYCLES, 1, cycles cpu_reset is held high after start (legal >= 1).
- TIMEOUT_CYCLES, 10000, maximum RUN cycles before timeout abort.
- CNT_W, 32, width of cycle_count, read_count, write_count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset of the monitor.
- start  in  1  single-cycle pulse: begin a run.
- cpu_reset  out  1  drives mips_cpu_harvard reset (active-high).
- cpu_active  in  1  CPU active output.
- cpu_register_v0  in  32  CPU register_v0 output.
- cpu_data_read  in  1  CPU data_read strobe.
- cpu_data_write  in  1  CPU data_write strobe.
- busy  out  1  high in HOLD, ARM, RUN.
- done  out  1  high in DONE, held until next start.
- timeout  out  1  run aborted at TIMEOUT_CYCLES.
- no_start_err  out  1  CPU not active on first cycle after reset release.
- rw_conflict  out  1  sticky: read and write strobes both high in one RUN cycle.
- v0_result  out  32  register_v0 captured at halt.
- cycle_count  out  CNT_W  RUN cycles with cpu_active=1.
- read_count  out  CNT_W  RUN cycles with cpu_data_read=1.
- write_count  out  CNT_W  RUN cycles with cpu_data_write=1.

Behaviour:
- reset low (async): state IDLE; cpu_reset=1; all other outputs, counters, flags = 0.
- States IDLE, HOLD, ARM, RUN, DONE. cpu_reset=1 in IDLE/HOLD/DONE, 0 in ARM/RUN (registered, glitch-free).
- IDLE/DONE + start: clear counters, flags, v0_result; -> HOLD; hold counter loaded with RESET_CYCLES-1.
- HOLD: decrement each cycle; at 0 -> ARM. cpu_reset high exactly RESET_CYCLES cycles.
- ARM (one cycle, cpu_reset=0): sample cpu_active; 1 -> RUN; 0 -> no_start_err=1, -> DONE.
- RUN, each cycle: cpu_active=1 -> cycle_count+1; read_count/write_count +1 per asserted strobe (both may increment same cycle; both high also sets rw_conflict). Strobes ignored outside RUN.
- RUN halt: cpu_active sampled 0 -> v0_result <= cpu_register_v0 same edge, -> DONE; done high the next cycle (1-cycle latency). Halt-cycle strobes not counted.
- RUN timeout: cycle_count reaches TIMEOUT_CYCLES with cpu_active=1 -> timeout=1, v0_result <= cpu_register_v0, -> DONE. Halt and timeout on same cycle: halt wins, timeout=0.
- Counters saturate at 2^CNT_W-1, never wrap.
- start in HOLD/ARM/RUN ignored. start in DONE restarts run (done drops next cycle).
- reset low mid-run: immediate IDLE, cpu_reset=1, results lost.
- done, timeout, no_start_err mutually consistent: timeout/no_start_err only ever set with done.

Decomposition:
- Package mips_run_pkg: state enum type (IDLE, HOLD, ARM, RUN, DONE), default timeout/reset-cycle constants.
- One sub-module: sat_counter (CNT_W param, clr, inc, saturating), instantiated three times.

Test Plan:
- Normal halt: start; CPU model active for 25 cycles, v0=32'h0000_0007, 4 reads, 2 writes -> done=1, v0_result=7, cycle_count=25, read_count=4, write_count=2, timeout=0.
- Reset timing: RESET_CYCLES=3, start -> cpu_reset high exactly 3 cycles after start, low on ARM cycle; busy high from cycle after start.
- Timeout: TIMEOUT_CYCLES=50, active never drops -> timeout=1, done=1, cycle_count=50, cpu_reset back to 1.
- No start: active stays 0 after reset release -> no_start_err=1, done=1 one cycle after ARM, cycle_count=0.
- Conflict/saturation: CNT_W=4, both strobes high 20 RUN cycles -> rw_conflict=1, read_count=write_count=15.
- Async reset mid-RUN at cycle 10 -> same-cycle IDLE, all outputs 0, cpu_reset=1; later start runs cleanly.
